pfd_digital: RTL and testbench
==============================

Name: pfd_digital

Overview:
- Clocked phase-frequency detector that drives the up/dn inputs of the PLL charge pump.
- Oversamples the reference and feedback clocks on a fast system clock and resolves which edge arrived first.
- Emits up/dn pulses, including a programmable both-high reset pulse that removes the dead zone.
- Also reports the last measured phase-error width and raises a lock flag after N consecutive small errors.

Parameters:
- TRST, 2: cycles up and dn are both high (reset/anti-dead-zone pulse); 0 treated as 1.
- CW, 8: width of the pulse-width and lock counters.
- LOCK_TOL, 1: maximum phase-error width (cycles) counted as "good".
- LOCK_CNT, 16: consecutive good comparisons required to assert lock.

Ports:
- clk  in  1  oversampling clock; all flops on rising edge.
- rstn  in  1  reset, asynchronous assert, active low.
- en  in  1  enable; 0 forces IDLE synchronously.
- ref_in  in  1  reference clock, asynchronous to clk.
- fb_in  in  1  divided feedback clock, asynchronous to clk.
- up  out  1  charge-pump up request.
- dn  out  1  charge-pump down request.
- err_width  out  CW  width of last completed phase-error pulse, in cycles.
- err_sign  out  1  1 = last error was ref-leads (up), 0 = fb-leads (dn).
- lock  out  1  lock indicator.

Behaviour:
- Reset (rstn=0, async): all flops 0; state IDLE; up=dn=lock=err_sign=0, err_width=0.
- Input path: ref_in and fb_in each pass through a 2-flop synchronizer plus a third delay flop.
  - rise = sync2 & ~sync3.
  - An input high at reset release produces one valid rising event.
- Latency: ref_in first sampled high at edge k -> rise visible after k+1 -> state change at edge k+2.
- up/dn are decoded from the state register (Moore), with no extra delay.
  - up = state in {UP, BOTH}; dn = state in {DN, BOTH}.
- FSM transitions, evaluated each cycle with en=1:
  - IDLE: ref_rise only -> UP; fb_rise only -> DN; both same cycle -> BOTH; none -> IDLE.
  - UP: fb_rise -> BOTH (ref_rise ignored, state saturates in UP); otherwise stay UP.
  - DN: ref_rise -> BOTH (fb_rise ignored); otherwise stay DN.
  - BOTH: held for max(TRST,1) cycles via a down-counter, then -> IDLE. All rises arriving during BOTH are dropped (blind zone).
- Width counter:
  - Loads 1 on entry to UP/DN; increments each cycle in UP/DN.
  - Saturates at 2^CW-1; no wrap.
- On BOTH entry:
  - err_width <= cycles spent in UP/DN (0 if entered from IDLE).
  - err_sign <= 1 if coming from UP, 0 if from DN; unchanged if from IDLE.
  - err_width/err_sign otherwise hold.
- Lock counter, updated on each BOTH entry:
  - err_width <= LOCK_TOL -> increment, saturating at LOCK_CNT.
  - Otherwise clear to 0 and deassert lock on the same edge.
  - lock = 1 on the edge where the counter reaches LOCK_CNT.
- Runaway: UP/DN with saturated width counter keeps up/dn asserted; lock forced 0 while saturated.
- en=0: next edge state=IDLE, up=dn=0, lock counter=0, lock=0.
  - Synchronizers keep running; err_* hold.
  - en rising resumes from IDLE; no spurious edge generated.
- rstn asserted mid-pulse: up/dn/lock drop immediately (async).

Test Plan:
- Reset: rstn=0 with ref_in=fb_in=1 toggling -> up=dn=lock=0, err_width=0; after release, first ref rise gives up at edge k+2.
- Ref leads by 5 cycles, TRST=2 -> up alone high 5 cycles, up&dn high 2 cycles, then both 0; err_width=5, err_sign=1.
- Fb leads by 3 cycles -> dn alone 3 cycles, 2-cycle BOTH; err_width=3, err_sign=0.
- Coincident edges (same sample) -> IDLE->BOTH; up=dn=1 for 2 cycles; err_width=0; lock counter +1.
- Lock sequence: 16 comparisons with 1-cycle error -> lock rises on 16th BOTH entry; a 4-cycle error then clears lock that edge; TRST=0 gives 1-cycle BOTH.
- Edge during BOTH / en drop: fb rise during BOTH is dropped (no DN); en=0 while in UP -> up=0 next edge, lock=0; ref held 300 cycles ahead -> err_width saturates at 255, no wrap.

Source files
------------

// File: rtl/pfd_digital.sv
// pfd_digital: oversampled phase-frequency detector with anti-dead-zone reset pulse, error-width report and lock detect.
module pfd_digital #(
  parameter int TRST     = 2,
  parameter int CW       = 8,
  parameter int LOCK_TOL = 1,
  parameter int LOCK_CNT = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          ref_in,
  input  logic          fb_in,
  output logic          up,
  output logic          dn,
  output logic [CW-1:0] err_width,
  output logic          err_sign,
  output logic          lock
);
  localparam int TR = (TRST < 1) ? 1 : TRST;
  localparam int RW = $clog2(TR + 1);
  localparam logic [RW-1:0] TR_LD = RW'(TR - 1);
  localparam logic [CW-1:0] TOL = CW'(LOCK_TOL);
  localparam logic [CW-1:0] LCNT = CW'(LOCK_CNT);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, UP, DN, BOTH} state_t;
  state_t state_q, state_d;
  logic [2:0] ref_q, fb_q;
  logic [RW-1:0] trst_q, trst_d;
  logic [CW-1:0] width_q, width_d, lcnt_q, lcnt_inc, ew;
  logic ref_rise, fb_rise, in_pulse, sat, enter_both, good;
  always_comb begin
    ref_rise = ref_q[1] & ~ref_q[2];
    fb_rise = fb_q[1] & ~fb_q[2];
    in_pulse = state_q == UP || state_q == DN;
    sat = in_pulse && width_q == '1;
    state_d = !en ? IDLE :
              state_q == IDLE ? (ref_rise && fb_rise ? BOTH : ref_rise ? UP : fb_rise ? DN : IDLE) :
              state_q == UP ? (fb_rise ? BOTH : UP) :
              state_q == DN ? (ref_rise ? BOTH : DN) :
              (trst_q == '0 ? IDLE : BOTH);
    enter_both = state_d == BOTH && state_q != BOTH;
    trst_d = enter_both ? TR_LD : (trst_q != '0 ? trst_q - RW'(1) : trst_q);
    width_d = (state_d == UP || state_d == DN) ?
              (state_d != state_q ? ONE : sat ? width_q : width_q + ONE) : '0;
    ew = state_q == IDLE ? '0 : width_q;
    good = ew <= TOL;
    lcnt_inc = lcnt_q == LCNT ? lcnt_q : lcnt_q + ONE;
  end
  // A runaway pulse (saturated width) can never be a good comparison, so lock is dropped early.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_q <= '0;
      fb_q <= '0;
      state_q <= IDLE;
      trst_q <= '0;
      width_q <= '0;
      lcnt_q <= '0;
      err_width <= '0;
      err_sign <= 1'b0;
      lock <= 1'b0;
    end else begin
      ref_q <= {ref_q[1:0], ref_in};
      fb_q <= {fb_q[1:0], fb_in};
      state_q <= state_d;
      trst_q <= trst_d;
      width_q <= width_d;
      if (enter_both) begin
        err_width <= ew;
        if (state_q != IDLE) err_sign <= state_q == UP;
        lcnt_q <= good ? lcnt_inc : '0;
        lock <= good && lcnt_inc == LCNT;
      end else if (!en) begin
        lcnt_q <= '0;
        lock <= 1'b0;
      end else if (sat) begin
        lock <= 1'b0;
      end
    end
  end
  assign up = state_q == UP || state_q == BOTH;
  assign dn = state_q == DN || state_q == BOTH;
endmodule

// File: tb/tb_pfd_digital.sv
// tb_pfd_digital: randomized edge-pair stimulus with a queue scoreboard checked whenever up&dn rises.
module tb_pfd_digital;
  logic clk = 0, rstn = 0, en = 0, ref_in = 0, fb_in = 0;
  logic up, dn, err_sign, lock;
  logic [7:0] err_width;
  logic up0, dn0, es0, lk0;
  logic [7:0] ew0;

  pfd_digital #(.TRST(2)) dut (.clk(clk), .rstn(rstn), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .up(up), .dn(dn), .err_width(err_width), .err_sign(err_sign), .lock(lock));
  pfd_digital #(.TRST(0)) dut0 (.clk(clk), .rstn(rstn), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .up(up0), .dn(dn0), .err_width(ew0), .err_sign(es0), .lock(lk0));

  always #5 clk = ~clk;

  typedef struct {int w; bit s; bit l; int run;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  int m_cnt = 0, m_w = 0;
  bit m_sign = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: error = edge separation in samples, clipped at 255; lock after 16 consecutive errors <= 1.
  function automatic void model(input bit lead_ref, input int d);
    m_w = d > 255 ? 255 : d;
    if (d != 0) m_sign = lead_ref;
    m_cnt = (m_w <= 1) ? (m_cnt < 16 ? m_cnt + 1 : 16) : 0;
    q.push_back('{m_w, m_sign, m_cnt == 16, d});
  endfunction

  bit pb = 0, pb0 = 0;
  int run = 0, bl = 0, bl0 = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      pb = 0; pb0 = 0; run = 0; bl = 0; bl0 = 0;
    end else begin
      if (up && dn && !pb) begin
        if (q.size() == 0) chk("unexpected_both", 1, 0);
        else begin
          e = q.pop_front();
          chk("err_width", err_width, e.w);
          chk("err_sign", err_sign, e.s);
          chk("lock", lock, e.l);
          chk("lead_run", run, e.run);
        end
      end
      if (up && dn) bl++;
      else begin
        if (pb) chk("both_len", bl, 2);
        bl = 0;
      end
      if (up0 && dn0) bl0++;
      else begin
        if (pb0) chk("both_len_trst0", bl0, 1);
        bl0 = 0;
      end
      run = (up ^ dn) ? run + 1 : 0;
      pb = up && dn;
      pb0 = up0 && dn0;
    end
  end

  task automatic cmp(input bit lead_ref, input int d, input bit blind = 0);
    bit lk;
    lk = (m_cnt == 16);
    model(lead_ref, d);
    for (int i = 0; i <= d + 12; i++) begin
      @(negedge clk);
      if (i == 0) begin if (lead_ref) ref_in = 1; else fb_in = 1; end
      if (i == d) begin if (lead_ref) fb_in = 1; else ref_in = 1; end
      if (blind && i == d + 1) fb_in = 0;
      if (blind && i == d + 2) fb_in = 1;
      if (i == 2) chk("pre_latency", lead_ref ? up : dn, 0);
      if (i == 3) chk("latency", lead_ref ? up : dn, 1);
      if (d >= 260 && i == 250) chk("runaway_pre_lock", lock, lk);
      if (d >= 260 && i == 259) begin
        chk("runaway_lock", lock, 0);
        chk("runaway_up", up, lead_ref);
      end
      if (i == d + 10) begin ref_in = 0; fb_in = 0; end
      if (i == d + 12) begin
        chk("idle_up", up, 0);
        chk("idle_dn", dn, 0);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic en_drop();
    @(negedge clk) ref_in = 1;
    repeat (3) @(negedge clk);
    chk("en_pre_up", up, 1);
    chk("en_pre_lock", lock, m_cnt == 16);
    en = 0;
    @(negedge clk);
    chk("en_off_up", up, 0);
    chk("en_off_dn", dn, 0);
    chk("en_off_lock", lock, 0);
    chk("en_hold_w", err_width, m_w);
    m_cnt = 0;
    ref_in = 0;
    repeat (6) @(negedge clk);
    en = 1;
    repeat (4) @(negedge clk);
    chk("en_resume_up", up, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    repeat (6) begin
      @(negedge clk);
      ref_in = ~ref_in;
      fb_in = 1'($urandom);
      chk("rst_up", up, 0);
      chk("rst_dn", dn, 0);
      chk("rst_lock", lock, 0);
      chk("rst_err_width", err_width, 0);
    end
    ref_in = 0; fb_in = 0;
    repeat (4) @(negedge clk);
    chk("rst_err_sign", err_sign, 0);
    rstn = 1; en = 1;
    repeat (4) @(negedge clk);
    cmp(1, 5);
    cmp(0, 3);
    cmp(1, 0);
    repeat (16) cmp(1, 1);
    cmp(0, 4);
    repeat (16) cmp(1'($urandom_range(0, 1)), 1);
    cmp(1, 300);
    repeat (16) cmp(0, 1);
    en_drop();
    cmp(1, 3, 1);
    repeat (30) cmp(1'($urandom_range(0, 1)), $urandom_range(0, 7));
    repeat (16) cmp(1, $urandom_range(0, 1));
    chk("queue_drained", q.size(), 0);
    @(negedge clk) ref_in = 1;
    repeat (4) @(negedge clk);
    chk("async_pre_up", up, 1);
    chk("async_pre_lock", lock, m_cnt == 16);
    #2 rstn = 0;
    #1;
    chk("async_up", up, 0);
    chk("async_lock", lock, 0);
    chk("async_err_width", err_width, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
